pipelined_recursive_doubling_adder: RTL and testbench
=====================================================

Name: pipelined_recursive_doubling_adder

Overview:
- Parametrised, pipelined successor to the team's 16-bit recursive-doubling (Kogge-Stone style) carry-lookahead adder.
- Registers the PGK generation, each doubling level and the sum stage.
- Adds an add/subtract mode, signed-overflow flag and valid/ready flow control with full-pipeline stall.
- Sits in datapaths that need one add per clock at high frequency, for example accumulators and address generators.

Parameters:
- WIDTH, 16, operand width. Must be a power of two and at least 2; any other value is an elaboration error.
- LEVELS, $clog2(WIDTH), number of doubling levels. Derived; must not be overridden.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous reset, active-high; clears all state.
- in_valid  input  1  operand beat is valid.
- in_ready  output  1  block accepts a beat this cycle.
- a  input  WIDTH  operand A; bit 0 is the LSB.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; used only when sub=0.
- sub  input  1  0 = A+B+cin; 1 = A-B, computed as A+~B+1.
- out_valid  output  1  result beat is valid.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  carry-out of the MSB. When sub=1, cout=1 means no borrow.
- ovf  output  1  two's-complement overflow of the operation.
- busy  output  1  at least one pipeline stage holds a valid beat.

Behaviour:
- Reset (asynchronous, immediate):
  - All stage valid bits clear, so out_valid=0 and busy=0.
  - sum, cout and ovf go to 0; all internal registers go to 0.
  - Beats in flight when reset asserts are discarded. After release, no output appears until a new beat is accepted.
- Stage 0 (accept):
  - Latches the kill/generate/propagate code for every bit, using the existing 2-bit encoding: 00 kill, 11 generate, 10 propagate.
  - Bit 0's code is resolved with the effective carry-in, which is cin when sub=0 and 1 when sub=1.
  - Also latches the effective B, a^b_eff, and the operand MSBs for the overflow calculation.
- Stages 1..LEVELS (doubling):
  - Stage k combines each bit i with bit i-2^(k-1), for i >= 2^(k-1).
  - Combine rule: result = upper if upper is 00 or 11, otherwise lower.
  - Bits below 2^(k-1) pass through unchanged.
- Final stage:
  - sum[0] = p0 ^ cin_eff; sum[i] = p[i] ^ carry[i-1].
  - cout = carry[WIDTH-1].
  - ovf = carry[WIDTH-1] ^ carry[WIDTH-2].
- Latency: LEVELS+2 cycles from the accepting edge to out_valid (6 for WIDTH=16). Throughput is one beat per cycle.
- Flow control:
  - Global enable: adv = !out_valid | out_ready; in_ready = adv.
  - A beat is accepted when in_valid & in_ready.
  - When adv=0, every stage register and valid bit holds.
  - When adv=1, each stage loads from the previous stage, including bubbles.
  - While out_valid=1 and out_ready=0, sum, cout and ovf stay stable.
- Bubbles:
  - An invalid stage carries valid=0.
  - Its data registers are don't-care internally, but out_valid must be 0 whenever no valid beat has reached the output.
- busy: OR of all stage valid bits, including the output stage.
- Wrap-around: the result is modulo 2^WIDTH; the overflow is reported only on cout/ovf.
- Arithmetic identities: sub=1 with a=b gives sum=0, cout=1, ovf=0. cin is ignored whenever sub=1.

Test Plan:
- WIDTH=16, sub=0: a=0xFFFF, b=0x0001, cin=0 -> after 6 cycles sum=0x0000, cout=1, ovf=0. Also a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
- WIDTH=16, sub=1: a=0x0005, b=0x0007, cin=1 -> sum=0xFFFE, cout=0, ovf=0. Also a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, ovf=1.
- Back-to-back: 20 random beats with out_ready=1 -> results arrive in order on 20 consecutive cycles, first one 6 cycles after the first accept, and all match a golden model.
- Backpressure: out_ready=0 for 5 cycles once out_valid=1 -> in_ready=0, the output holds its value, no beat is lost or duplicated, and the order is preserved after release.
- Reset mid-stream: assert rst with 3 beats in flight -> out_valid and busy drop immediately and no stale result appears afterwards. A new beat a=1, b=2 then yields sum=3.
- Parameter sweep: WIDTH=2, 8 and 32 with exhaustive or random operands -> latency equals LEVELS+2 and results match the golden model.

Source files
------------

// File: rtl/pipelined_recursive_doubling_adder.sv
// Pipelined recursive-doubling (Kogge-Stone) adder/subtractor with valid/ready
// flow control. Register stages: one PGK stage, LEVELS doubling stages, and
// one sum stage. A single global enable stalls the whole pipe.

// One prefix cell: a resolved upper code (kill/generate) wins; a propagating
// upper code defers to the lower span.
module pipelined_recursive_doubling_adder_cell (
  input  logic [1:0] upper,
  input  logic [1:0] lower,
  output logic [1:0] result
);
  assign result = (upper[1] == upper[0]) ? upper : lower;
endmodule

module pipelined_recursive_doubling_adder #(
  parameter int WIDTH  = 16,
  parameter int LEVELS = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);
  localparam int STAGES = LEVELS + 1;

  typedef logic [1:0] pgk_t;
  localparam pgk_t KILL = 2'b00;
  localparam pgk_t GEN  = 2'b11;
  localparam pgk_t PROP = 2'b10;

  generate
    if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
      $error("pipelined_recursive_doubling_adder: WIDTH must be a power of two >= 2");
    end
    if (LEVELS != $clog2(WIDTH)) begin : g_bad_levels
      $error("pipelined_recursive_doubling_adder: LEVELS is derived and must not be overridden");
    end
  endgenerate

  // vld_pipe[0] is the PGK stage, vld_pipe[STAGES] the output stage.
  logic [STAGES:0]                vld_pipe;
  pgk_t [LEVELS:0][WIDTH-1:0]     code_q;
  logic [LEVELS:0][WIDTH-1:0]     p_q;
  logic [LEVELS:0]                cin_q;

  logic adv;
  assign adv       = !vld_pipe[STAGES] | out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_pipe[STAGES];
  assign busy      = |vld_pipe;

  // Operand conditioning: subtraction is A + ~B + 1, so cin is forced to 1.
  logic [WIDTH-1:0] b_eff, p_in, g_in;
  logic             cin_eff;
  pgk_t [WIDTH-1:0] code_in;

  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub | cin;
  assign p_in    = a ^ b_eff;
  assign g_in    = a & b_eff;

  // Per-bit PGK code; bit 0 is resolved against the effective carry-in so
  // every code is kill/generate once the prefix network completes.
  always_comb begin
    code_in = '0;
    for (int i = 0; i < WIDTH; i++)
      code_in[i] = g_in[i] ? GEN : (p_in[i] ? PROP : KILL);
    if (code_in[0] == PROP)
      code_in[0] = {2{cin_eff}};
  end

  // Doubling network: level k looks 2^(k-1) bits down.
  pgk_t [LEVELS:1][WIDTH-1:0] lvl_d;

  generate
    for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
      localparam int D = 1 << (k - 1);
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (i >= D) begin : g_cell
          pipelined_recursive_doubling_adder_cell u_cell (
            .upper  (code_q[k-1][i]),
            .lower  (code_q[k-1][i-D]),
            .result (lvl_d[k][i])
          );
        end else begin : g_pass
          assign lvl_d[k][i] = code_q[k-1][i];
        end
      end
    end
  endgenerate

  // Carries out of each bit after the full prefix; codes are kill/generate here.
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] sum_d;

  always_comb begin
    carry = '0;
    for (int i = 0; i < WIDTH; i++)
      carry[i] = (code_q[LEVELS][i] == GEN);
    sum_d = p_q[LEVELS] ^ {carry[WIDTH-2:0], cin_q[LEVELS]};
  end

  // Pipeline advance: every stage (valid bits included) moves together or holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      code_q   <= '0;
      p_q      <= '0;
      cin_q    <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      ovf      <= 1'b0;
    end else if (adv) begin
      vld_pipe  <= {vld_pipe[STAGES-1:0], in_valid};
      code_q[0] <= code_in;
      p_q[0]    <= p_in;
      cin_q[0]  <= cin_eff;
      for (int k = 1; k <= LEVELS; k++) begin
        code_q[k] <= lvl_d[k];
        p_q[k]    <= p_q[k-1];
        cin_q[k]  <= cin_q[k-1];
      end
      sum  <= sum_d;
      cout <= carry[WIDTH-1];
      ovf  <= carry[WIDTH-1] ^ carry[WIDTH-2];
    end
  end

endmodule

// File: tb/tb_pipelined_recursive_doubling_adder.sv
// Directed bench for pipelined_recursive_doubling_adder: reset, hand vectors,
// streaming, backpressure, mid-stream reset, and a WIDTH sweep.
module tb_pipelined_recursive_doubling_adder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf, busy;
  logic [15:0] a, b, sum;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipelined_recursive_doubling_adder #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
  );

  // Sweep instances share one stimulus bus, truncated to each width.
  logic        sw_valid, sw_cin, sw_sub;
  logic [31:0] sw_a, sw_b;
  logic [2:0]  sw_ir, sw_ov, sw_co, sw_of, sw_busy;
  logic [31:0] sw_sum [3];

  generate
    for (genvar g = 0; g < 3; g++) begin : g_sw
      localparam int W = (g == 0) ? 2 : ((g == 1) ? 8 : 32);
      logic [W-1:0] s;
      pipelined_recursive_doubling_adder #(.WIDTH(W)) u_sw (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_ir[g]),
        .a(sw_a[W-1:0]), .b(sw_b[W-1:0]), .cin(sw_cin), .sub(sw_sub),
        .out_valid(sw_ov[g]), .out_ready(1'b1),
        .sum(s), .cout(sw_co[g]), .ovf(sw_of[g]), .busy(sw_busy[g])
      );
      assign sw_sum[g] = 32'(s);
    end
  endgenerate

  // Golden model: {ovf, cout, sum} of a w-bit add/subtract.
  function automatic logic [33:0] model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                        input logic cv, input logic sv);
    logic [32:0] mask, aa, bb, full;
    logic        ci, co, of;
    mask = (33'd1 << w) - 33'd1;
    aa   = {1'b0, av} & mask;
    bb   = (sv ? ~{1'b0, bv} : {1'b0, bv}) & mask;
    ci   = sv | cv;
    full = aa + bb + {32'd0, ci};
    co   = full[w];
    of   = (aa[w-1] == bb[w-1]) && (full[w-1] != aa[w-1]);
    return {of, co, full[31:0] & mask[31:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single beat: latency counted in edges, accepting edge included.
  task automatic run_one(input logic [15:0] av, input logic [15:0] bv, input logic cv, input logic sv,
                         input logic [15:0] es, input logic ec, input logic eo, input string tag);
    int lat;
    a = av; b = bv; cin = cv; sub = sv; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, " latency"}, lat, 6);
    chk({tag, " sum"}, sum, es);
    chk({tag, " cout"}, cout, ec);
    chk({tag, " ovf"}, ovf, eo);
    tick();
    chk({tag, " drained"}, out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [15:0] ra [20];
  logic [15:0] rb [20];
  logic        rc [20];
  logic        rs [20];
  logic [33:0] e16 [20];
  logic [31:0] va [64];
  logic [31:0] vb [64];
  logic        vc [64];
  logic        vs [64];
  logic [33:0] m, prev;
  int          sent, rcv, stall_left, w, lat, idx;
  logic        started, have_prev, ev;

  initial begin
    in_valid = 0; a = 0; b = 0; cin = 0; sub = 0; out_ready = 1;
    sw_valid = 0; sw_a = 0; sw_b = 0; sw_cin = 0; sw_sub = 0;

    // Reset state
    #12;
    chk("rst out_valid", out_valid, 0);
    chk("rst busy", busy, 0);
    chk("rst sum", sum, 0);
    chk("rst cout", cout, 0);
    chk("rst ovf", ovf, 0);
    chk("rst in_ready", in_ready, 1);
    rst = 1'b0;
    tick(); tick(); tick();
    chk("idle out_valid", out_valid, 0);

    // Hand-computed vectors
    run_one(16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0, "add wrap");
    run_one(16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1, "add ovf");
    run_one(16'h00FF, 16'h0001, 1, 0, 16'h0101, 0, 0, "add cin");
    run_one(16'h0005, 16'h0007, 1, 1, 16'hFFFE, 0, 0, "sub borrow");
    run_one(16'h8000, 16'h0001, 0, 1, 16'h7FFF, 1, 1, "sub ovf");
    run_one(16'h1234, 16'h1234, 0, 1, 16'h0000, 1, 0, "sub equal");

    // Back-to-back: 20 beats, results on 20 consecutive cycles
    for (int j = 0; j < 20; j++) begin
      ra[j] = 16'($urandom); rb[j] = 16'($urandom);
      rc[j] = 1'($urandom);  rs[j] = 1'($urandom);
      e16[j] = model(16, {16'd0, ra[j]}, {16'd0, rb[j]}, rc[j], rs[j]);
    end
    for (int c = 0; c < 30; c++) begin
      if (c < 20) begin
        in_valid = 1; a = ra[c]; b = rb[c]; cin = rc[c]; sub = rs[c];
      end else in_valid = 0;
      tick();
      chk("b2b valid", out_valid, (c >= 5 && c < 25));
      if (c >= 5 && c < 25 && out_valid)
        chk($sformatf("b2b beat%0d", c - 5), {ovf, cout, sum}, {e16[c-5][33:32], e16[c-5][15:0]});
    end

    // Backpressure: 5-cycle stall once output appears
    for (int j = 0; j < 10; j++) begin
      ra[j] = 16'($urandom); rb[j] = 16'($urandom);
      rc[j] = 1'($urandom);  rs[j] = 1'($urandom);
      e16[j] = model(16, {16'd0, ra[j]}, {16'd0, rb[j]}, rc[j], rs[j]);
    end
    sent = 0; rcv = 0; stall_left = 0; started = 0; have_prev = 0; prev = '0;
    for (int cyc = 0; cyc < 60 && rcv < 10; cyc++) begin
      if (out_valid && !started) begin started = 1; stall_left = 5; end
      out_ready = (stall_left == 0);
      if (sent < 10) begin
        in_valid = 1; a = ra[sent]; b = rb[sent]; cin = rc[sent]; sub = rs[sent];
      end else in_valid = 0;
      #1;
      if (stall_left > 0) begin
        chk("bp in_ready", in_ready, 0);
        chk("bp out_valid", out_valid, 1);
        if (have_prev) chk("bp hold", {ovf, cout, sum}, prev[17:0]);
        prev = {16'd0, ovf, cout, sum};
        have_prev = 1;
        stall_left--;
      end
      if (out_valid && out_ready) begin
        chk($sformatf("bp beat%0d", rcv), {ovf, cout, sum}, {e16[rcv][33:32], e16[rcv][15:0]});
        rcv++;
      end
      if (in_valid && in_ready) sent++;
      tick();
    end
    chk("bp received", rcv, 10);
    chk("bp stalled", started, 1);
    in_valid = 0; out_ready = 1;
    tick(); tick(); tick(); tick(); tick(); tick(); tick();
    chk("bp idle busy", busy, 0);

    // Reset with 3 beats in flight
    for (int j = 0; j < 3; j++) begin
      in_valid = 1; a = 16'(j + 100); b = 16'(j + 7); cin = 0; sub = 0;
      tick();
    end
    in_valid = 0;
    tick();
    chk("mid busy before", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid out_valid", out_valid, 0);
    chk("mid busy", busy, 0);
    chk("mid sum", sum, 0);
    #2 rst = 1'b0;
    for (int j = 0; j < 10; j++) begin
      tick();
      chk("mid stale", out_valid, 0);
    end
    run_one(16'h0001, 16'h0002, 0, 0, 16'h0003, 0, 0, "after rst");

    // Width sweep: WIDTH=2 exhaustive on low bits, 8 and 32 random
    for (int j = 0; j < 64; j++) begin
      va[j] = ($urandom & 32'hFFFF_FFFC) | 32'(j & 3);
      vb[j] = ($urandom & 32'hFFFF_FFFC) | 32'((j >> 2) & 3);
      vc[j] = 1'((j >> 4) & 1);
      vs[j] = 1'((j >> 5) & 1);
    end
    for (int c = 0; c < 72; c++) begin
      if (c < 64) begin
        sw_valid = 1; sw_a = va[c]; sw_b = vb[c]; sw_cin = vc[c]; sw_sub = vs[c];
      end else sw_valid = 0;
      tick();
      for (int g = 0; g < 3; g++) begin
        w   = (g == 0) ? 2 : ((g == 1) ? 8 : 32);
        lat = $clog2(w) + 2;
        idx = c - lat + 1;
        ev  = (idx >= 0 && idx < 64);
        chk($sformatf("sweep w%0d valid", w), sw_ov[g], ev);
        if (ev && sw_ov[g]) begin
          m = model(w, va[idx], vb[idx], vc[idx], vs[idx]);
          chk($sformatf("sweep w%0d beat%0d", w, idx), {sw_of[g], sw_co[g], sw_sum[g]}, m);
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
